// File: rtl/control_timing_unit_if.sv
// Control-path bundle between the sequencer controls, the IR opcode field and the
// timing-state generator.
interface control_timing_unit_if #(
    parameter int T_WIDTH   = 3,
    parameter int OP_WIDTH  = 6,
    parameter int NUM_OPS   = 34,
    parameter int CNT_WIDTH = 16
) ();
    logic                      inc;
    logic                      hold;
    logic                      clear;
    logic                      load;
    logic [T_WIDTH-1:0]        load_value;
    logic                      op_latch;
    logic [OP_WIDTH-1:0]       op_in;
    logic [T_WIDTH-1:0]        sc_out;
    logic [(1<<T_WIDTH)-1:0]   t;
    logic [NUM_OPS-1:0]        d;
    logic                      op_illegal;
    logic                      wrap;
    logic [CNT_WIDTH-1:0]      instr_count;

    modport master (
        output inc, hold, clear, load, load_value, op_latch, op_in,
        input  sc_out, t, d, op_illegal, wrap, instr_count
    );

    modport slave (
        input  inc, hold, clear, load, load_value, op_latch, op_in,
        output sc_out, t, d, op_illegal, wrap, instr_count
    );
endinterface

// File: rtl/control_timing_unit.sv
// Timing-state counter with programmable wrap, opcode latch/decoder and
// retired-instruction counter for the multi-cycle control path.
module control_timing_unit #(
    parameter int T_WIDTH   = 3,
    parameter int MAX_STATE = 7,
    parameter int OP_WIDTH  = 6,
    parameter int NUM_OPS   = 34,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_timing_unit_if.slave  bus
);
    localparam int                  T_BITS  = 1 << T_WIDTH;
    localparam logic [T_WIDTH-1:0]  MAX_S   = T_WIDTH'(MAX_STATE);
    localparam logic [OP_WIDTH:0]   NUM_OPS_W = (OP_WIDTH+1)'(NUM_OPS);

    logic [T_WIDTH-1:0]   sc_q, sc_d;
    logic                 wrap_q, wrap_d;
    logic [NUM_OPS-1:0]   d_q, d_d;
    logic                 op_illegal_q, op_illegal_d;
    logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
    logic [T_BITS-1:0]    t_dec;
    logic                 op_legal;

    always_comb begin
        sc_d   = sc_q;
        wrap_d = 1'b0;
        if (bus.clear) begin
            sc_d = '0;
        end else if (bus.load) begin
            sc_d = (bus.load_value > MAX_S) ? MAX_S : bus.load_value;
        end else if (bus.hold) begin
            sc_d = sc_q;
        end else if (bus.inc) begin
            if (sc_q == MAX_S) begin
                sc_d   = '0;
                wrap_d = 1'b1;
            end else begin
                sc_d = sc_q + 1'b1;
            end
        end
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (bus.clear) instr_count_d = instr_count_q + CNT_WIDTH'(1);
    end

    // Illegal opcodes fall out of the decode loop as all-zero D.
    always_comb begin
        op_legal     = ({1'b0, bus.op_in} < NUM_OPS_W);
        d_d          = d_q;
        op_illegal_d = op_illegal_q;
        if (bus.op_latch) begin
            for (int i = 0; i < NUM_OPS; i++) d_d[i] = (bus.op_in == OP_WIDTH'(i));
            op_illegal_d = ~op_legal;
        end
    end

    always_comb begin
        t_dec = '0;
        for (int i = 0; i < T_BITS; i++) t_dec[i] = (sc_q == T_WIDTH'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q          <= '0;
            wrap_q        <= 1'b0;
            d_q           <= '0;
            op_illegal_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            sc_q          <= sc_d;
            wrap_q        <= wrap_d;
            d_q           <= d_d;
            op_illegal_q  <= op_illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.sc_out      = sc_q;
    assign bus.t           = t_dec;
    assign bus.d           = d_q;
    assign bus.op_illegal  = op_illegal_q;
    assign bus.wrap        = wrap_q;
    assign bus.instr_count = instr_count_q;
endmodule
